param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_array.sv | 67 ++++++
 rtl/param_ram.sv | 115 +++++++++++
 tb/tb_param_ram.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for param_ram: FSM state encoding, byte width, byte parity.
// The parity helper is used when RAM_PARITY_EN is defined.
package ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        INIT,
        IDLE
    } ram_state_e;

    // Even parity: the stored bit makes the total number of ones in byte+bit even.
    function automatic logic even_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_W storage with a byte-enabled write port and a registered read port.
// With RAM_PARITY_EN defined, one parity bit per byte is stored alongside the data.
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned NB    = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     wbe,
`ifdef RAM_PARITY_EN
    input  logic [NB-1:0]     wpar,
    output logic [NB-1:0]     rpar,
`endif
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Storage is deliberately not reset; the clear sequence defines its contents.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wbe[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read register samples the old word, so a same-edge write is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wbe[i]) par_mem[waddr][i] <= wpar[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpar <= '0;
        end else if (re) begin
            rpar <= par_mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/param_ram.sv
// Parameterised single-port RAM with a self-clearing INIT phase and a valid/ready request port.
// Define RAM_PARITY_EN to add per-byte even parity and the par_err output.
module param_ram
    import ram_pkg::*;
#(
    parameter int unsigned           DATA_W   = 8,
    parameter int unsigned           ADDR_W   = 8,
    parameter logic [DATA_W-1:0]     INIT_VAL = '0,
    localparam int unsigned          NB       = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NB-1:0]     req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
`ifdef RAM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rsp_valid_q;

    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [NB-1:0]     arr_wbe;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_waddr = req_addr;
        arr_wdata = req_wdata;
        arr_wbe   = req_be;
        unique case (state_q)
            INIT: begin
                arr_we    = 1'b1;
                arr_waddr = cnt_q;
                arr_wdata = INIT_VAL;
                arr_wbe   = '1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                arr_we    = req_valid && req_we;
                arr_re    = req_valid && !req_we;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= arr_re;
        end
    end

    assign rsp_valid = rsp_valid_q;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] wpar, rpar, par_bad;

    always_comb begin
        wpar    = '0;
        par_bad = '0;
        for (int i = 0; i < int'(NB); i++) begin
            wpar[i]    = even_par(arr_wdata[i*BYTE_W +: BYTE_W]);
            par_bad[i] = rpar[i] ^ even_par(rsp_rdata[i*BYTE_W +: BYTE_W]);
        end
    end

    assign par_err = rsp_valid_q && (|par_bad);
`endif

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wbe   (arr_wbe),
`ifdef RAM_PARITY_EN
        .wpar  (wpar),
        .rpar  (rpar),
`endif
        .re    (arr_re),
        .raddr (req_addr),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_param_ram.sv
// Randomised self-checking bench for param_ram (DATA_W=32, ADDR_W=4) against a word-array model.
// The parity corruption test runs only when RAM_PARITY_EN is defined.
module tb_param_ram;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned NB       = 4;
    localparam logic [31:0] INIT_VAL = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;
`ifdef RAM_PARITY_EN
    logic        par_err;
`endif

    param_ram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
`ifdef RAM_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: plain word array plus a countdown of remaining clear cycles.
    logic [31:0] model_mem [DEPTH];
    bit          corrupt   [DEPTH];
    int          init_left;
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic drive_rand();
        drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)));
    endtask

    // One clock: predict from the inputs presented, advance, compare.
    task automatic do_cycle();
        bit          rdy, rd, wr, pe;
        logic [31:0] d;
        rdy = (init_left == 0);
        check_eq("req_ready", 64'(req_ready), 64'(rdy));
        check_eq("init_done", 64'(init_done), 64'(rdy));
        rd = rdy && req_valid && !req_we;
        wr = rdy && req_valid && req_we;
        d  = '0;
        pe = 1'b0;
        if (rd) begin
            d  = model_mem[req_addr];
            pe = corrupt[req_addr];
        end
        if (wr) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (req_be[b]) model_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
            end
            if (req_be[0]) corrupt[req_addr] = 1'b0;
        end
        if (init_left > 0) init_left--;
        @(posedge clk);
        #1;
        if (rd) last_rd = d;
        check_eq("rsp_valid", 64'(rsp_valid), 64'(rd));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(last_rd));
`ifdef RAM_PARITY_EN
        check_eq("par_err", 64'(par_err), 64'(rd && pe));
`endif
    endtask

    // Assert reset mid-cycle (before the next edge) and check the asynchronous response.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_init_done", 64'(init_done), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
`ifdef RAM_PARITY_EN
        check_eq("rst_par_err", 64'(par_err), 64'd0);
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n     = 1'b1;
        init_left = DEPTH;
        last_rd   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            model_mem[i] = INIT_VAL;
            corrupt[i]   = 1'b0;
        end
    endtask

    initial begin
        int not_ready;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        apply_reset();

        // Clear phase with random (ignored) requests; count cycles without ready.
        not_ready = 0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            if (!req_ready) not_ready++;
            drive_rand();
            do_cycle();
        end
        check_eq("clear_len", 64'(not_ready), 64'd16);

        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
            do_cycle();
        end

        // Byte-enabled write merged with the cleared word.
        drive(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
        do_cycle();
        drive(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        do_cycle();
        check_eq("be_merge", 64'(rsp_rdata), 64'h00BB00DD);

        // Back-to-back reads keep order.
        drive(1'b1, 1'b1, 4'd1, 32'h11111111, 4'hF);
        do_cycle();
        drive(1'b1, 1'b1, 4'd2, 32'h22222222, 4'hF);
        do_cycle();
        drive(1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        do_cycle();
        check_eq("b2b_rd1", 64'(rsp_rdata), 64'h11111111);
        drive(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
        do_cycle();
        check_eq("b2b_rd2", 64'(rsp_rdata), 64'h22222222);
        drive(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        do_cycle();
        check_eq("b2b_rd3", 64'(rsp_rdata), 64'h00BB00DD);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        do_cycle();

`ifdef RAM_PARITY_EN
        dut.u_array.mem[7][0] = ~dut.u_array.mem[7][0];
        model_mem[7][0] = ~model_mem[7][0];
        corrupt[7] = 1'b1;
        drive(1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
        do_cycle();
        check_eq("par_err_bad", 64'(par_err), 64'd1);
        drive(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
        do_cycle();
        check_eq("par_err_good", 64'(par_err), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            drive_rand();
            do_cycle();
        end

        // Reset lands while a read of addr 5 is being presented; no response may follow.
        drive(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
        do_cycle();
        drive(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
        apply_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_cycle();
        end
        check_eq("rst_clear_ready", 64'(req_ready), 64'd1);
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
            do_cycle();
        end
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
